// File: rtl/v3_param.sv
// Shared constants and types for the v3 shaping chain.
// The pulse generator's sample width matches the trapezoidal filter's input width.
package v3_param;

    localparam int SIZE_OUT  = 17;
    localparam int SIZE_AMP  = 16;
    localparam int SIZE_PER  = 16;
    localparam int SIZE_CNT  = 8;
    localparam int TAU_SHIFT = 4;

    typedef enum logic {IDLE, RUN} pg_state_t;

endpackage

// File: rtl/v3_decay_acc.sv
// Exponential-decay tail accumulator: each cycle the tail loses 2^-TAU_SHIFT of itself
// (at least 1 while non-zero) and gains amp when fire is high, saturating at full scale.
module v3_decay_acc
    import v3_param::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                fire,
    input  logic [SIZE_AMP-1:0] amp,
    output logic [SIZE_OUT-1:0] sample
);

    logic [SIZE_OUT-1:0] tail;
    logic [SIZE_OUT-1:0] dec;
    logic [SIZE_OUT:0]   sum;

    always_comb begin
        dec = tail >> TAU_SHIFT;
        // Small tails would otherwise stall above zero forever.
        if (dec == '0 && tail != '0) begin
            dec = SIZE_OUT'(1);
        end
        sum = {1'b0, tail} - {1'b0, dec} + (fire ? (SIZE_OUT+1)'(amp) : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tail <= '0;
        end else begin
            tail <= sum[SIZE_OUT] ? '1 : sum[SIZE_OUT-1:0];
        end
    end

    assign sample = tail;

endmodule

// File: rtl/v3_pulse_gen.sv
// Synthetic detector-pulse source: a command launches cmd_count pulses of height cmd_amp,
// cmd_period cycles apart, riding on an exponentially decaying tail.
module v3_pulse_gen
    import v3_param::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [SIZE_AMP-1:0] cmd_amp,
    input  logic [SIZE_PER-1:0] cmd_period,
    input  logic [SIZE_CNT-1:0] cmd_count,
    output logic [SIZE_OUT-1:0] output_data,
    output logic                pulse_mark
);

    // Command handshake: accepted when cmd_valid && cmd_ready at a rising edge;
    // cmd_ready is high only in IDLE, and cmd_valid is ignored while a run is active.

    pg_state_t           state, state_nxt;
    logic [SIZE_AMP-1:0] amp_q, amp_nxt;
    logic [SIZE_PER-1:0] period_q, period_nxt;
    logic [SIZE_PER-1:0] per_cnt, per_cnt_nxt;
    logic [SIZE_CNT-1:0] remaining, remaining_nxt;
    logic                fire;
    logic                handshake;
    logic                mark_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            amp_q     <= '0;
            period_q  <= '0;
            per_cnt   <= '0;
            remaining <= '0;
            mark_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            amp_q     <= amp_nxt;
            period_q  <= period_nxt;
            per_cnt   <= per_cnt_nxt;
            remaining <= remaining_nxt;
            mark_q    <= fire;
        end
    end

    always_comb begin
        state_nxt     = state;
        amp_nxt       = amp_q;
        period_nxt    = period_q;
        per_cnt_nxt   = per_cnt;
        remaining_nxt = remaining;
        fire          = 1'b0;
        cmd_ready     = (state == IDLE);
        handshake     = cmd_valid && cmd_ready;

        if (state == IDLE) begin
            if (handshake) begin
                amp_nxt       = cmd_amp;
                period_nxt    = (cmd_period == '0) ? SIZE_PER'(1) : cmd_period;
                remaining_nxt = cmd_count;
                per_cnt_nxt   = '0;
                // A zero-count command is consumed without starting a run.
                if (cmd_count != '0) begin
                    state_nxt = RUN;
                end
            end
        end else begin
            if (per_cnt == '0) begin
                fire          = 1'b1;
                per_cnt_nxt   = period_q - SIZE_PER'(1);
                remaining_nxt = remaining - SIZE_CNT'(1);
                if (remaining == SIZE_CNT'(1)) begin
                    state_nxt = IDLE;
                end
            end else begin
                per_cnt_nxt = per_cnt - SIZE_PER'(1);
            end
        end
    end

    v3_decay_acc u_decay_acc (
        .clk    (clk),
        .reset  (reset),
        .fire   (fire),
        .amp    (amp_q),
        .sample (output_data)
    );

    assign pulse_mark = mark_q;

endmodule

// File: tb/tb_v3_pulse_gen.sv
// Bench for v3_pulse_gen: cycle-indexed reference model feeding an expected queue,
// a negedge monitor, directed scenarios with fixed values, then random traffic.
module tb_v3_pulse_gen;
    import v3_param::*;

    localparam int W    = SIZE_OUT + 2;
    localparam int MAXV = (1 << SIZE_OUT) - 1;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [SIZE_AMP-1:0] cmd_amp = '0;
    logic [SIZE_PER-1:0] cmd_period = '0;
    logic [SIZE_CNT-1:0] cmd_count = '0;
    logic [SIZE_OUT-1:0] output_data;
    logic                pulse_mark;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    v3_pulse_gen dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_amp     (cmd_amp),
        .cmd_period  (cmd_period),
        .cmd_count   (cmd_count),
        .output_data (output_data),
        .pulse_mark  (pulse_mark)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a run is a schedule of absolute fire cycles, each carrying its amp.
    int     fire_amp[int];
    int     mcyc = 0;
    int     busy_until = -1;
    longint m_tail = 0;

    always @(posedge clk) begin
        longint dec;
        longint nxt;
        bit     f;
        bit     rdy;
        int     p;
        rdy = (mcyc > busy_until);
        f   = 1'b0;
        if (reset) begin
            m_tail = 0;
            fire_amp.delete();
            busy_until = mcyc;
        end else begin
            f   = fire_amp.exists(mcyc);
            dec = m_tail >> TAU_SHIFT;
            if (dec == 0 && m_tail != 0) dec = 1;
            nxt = m_tail - dec + (f ? longint'(fire_amp[mcyc]) : 0);
            m_tail = (nxt > MAXV) ? MAXV : nxt;
            if (cmd_valid && rdy && cmd_count != 0) begin
                p = (cmd_period == 0) ? 1 : int'(cmd_period);
                for (int k = 0; k < int'(cmd_count); k++)
                    fire_amp[mcyc + 1 + k * p] = int'(cmd_amp);
                busy_until = mcyc + 1 + (int'(cmd_count) - 1) * p;
            end
        end
        mcyc++;
        exp_q.push_back({m_tail[SIZE_OUT-1:0], f, (mcyc > busy_until)});
    end

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_output_data", output_data, e[W-1:2]);
            check("sb_pulse_mark", pulse_mark, e[1]);
            check("sb_cmd_ready", cmd_ready, e[0]);
        end
    end

    task automatic send(input int amp, input int period, input int count);
        @(posedge clk); #1;
        cmd_valid  = 1'b1;
        cmd_amp    = SIZE_AMP'(amp);
        cmd_period = SIZE_PER'(period);
        cmd_count  = SIZE_CNT'(count);
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!(cmd_ready && output_data == 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check(name, (k < 3000), 1);
    endtask

    initial begin
        int exp1[4];
        int exp2[5];
        int exp3[3];
        int marks;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_output_data", output_data, 0);
        check("reset_pulse_mark", pulse_mark, 0);
        check("reset_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1 reset = 1'b0;

        // Single pulse and its decay.
        exp1 = '{1600, 1500, 1407, 1320};
        send(1600, 10, 1);
        @(negedge clk);
        check("c1_ready_low", cmd_ready, 0);
        check("c1_no_mark", pulse_mark, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("single_data", output_data, exp1[i]);
            check("single_mark", pulse_mark, (i == 0) ? 1 : 0);
            check("single_ready", cmd_ready, 1);
        end
        wait_quiet("single_decay_to_zero");
        repeat (20) @(negedge clk);
        check("tail_holds_zero", output_data, 0);

        // Two pulses piling up.
        exp2 = '{1600, 1500, 1407, 1320, 2838};
        send(1600, 4, 2);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("pileup_data", output_data, exp2[i]);
            check("pileup_mark", pulse_mark, (i == 0 || i == 4) ? 1 : 0);
        end
        check("pileup_ready_after_last", cmd_ready, 1);
        wait_quiet("pileup_quiet");

        // Period 0 acts as 1; saturation at full scale.
        exp3 = '{65535, 126975, 131071};
        send(65535, 0, 3);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sat_data", output_data, exp3[i]);
            check("sat_mark", pulse_mark, 1);
        end
        wait_quiet("sat_quiet");

        // Reset in the middle of a run.
        send(1000, 5, 10);
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("abort_data_zero", output_data, 0);
        check("abort_ready", cmd_ready, 1);
        marks = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            marks += int'(pulse_mark);
        end
        check("abort_no_marks", marks, 0);

        // cmd_valid held during a run: only the accepted command's pulses appear.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_amp = 16'd500; cmd_period = 16'd3; cmd_count = 8'd2;
        @(posedge clk); #1;
        cmd_amp = 16'd9999; cmd_period = 16'd1; cmd_count = 8'd5;
        marks = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            marks += int'(pulse_mark);
            if (i == 4) cmd_valid = 1'b0;
        end
        check("held_valid_marks", marks, 2);
        wait_quiet("held_quiet");

        // Zero-count command is consumed without a run.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_amp = 16'd777; cmd_period = 16'd2; cmd_count = 8'd0;
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("zero_count_ready", cmd_ready, 1);
        marks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            marks += int'(pulse_mark);
        end
        check("zero_count_marks", marks, 0);
        check("zero_count_data", output_data, 0);

        // Random traffic, checked by the scoreboard only.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            reset      = ($urandom_range(0, 80) == 0);
            cmd_valid  = ($urandom_range(0, 3) == 0);
            cmd_amp    = ($urandom_range(0, 3) == 0) ? SIZE_AMP'($urandom_range(40000, 65535))
                                                     : SIZE_AMP'($urandom_range(0, 3000));
            cmd_period = SIZE_PER'($urandom_range(0, 6));
            cmd_count  = SIZE_CNT'($urandom_range(0, 5));
        end
        @(posedge clk); #1;
        reset = 1'b0;
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/v3_pulse_gen.md
# v3_pulse_gen

Synthetic detector-pulse source for the v3 shaping chain. On command it emits a stream of exponentially decaying pulses of programmable amplitude, spacing and count, one sample per clock, in the unsigned format the v3 trapezoidal filter consumes on its `input_data`. It replaces the ADC in bench and self-test configurations and drives the filter input directly.

## Interface

- `SIZE_OUT`, 17, sample width; equals the filter's `SIZE_IN`.
- `SIZE_AMP`, 16, amplitude width.
- `SIZE_PER`, 16, period counter width.
- `SIZE_CNT`, 8, pulse count width.
- `TAU_SHIFT`, 4, decay shift; per-sample decay factor is 1 - 2^-TAU_SHIFT.

Ports:

- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block idle and able to accept.
- `cmd_amp`  in  SIZE_AMP  step added per pulse.
- `cmd_period`  in  SIZE_PER  cycles between pulses.
- `cmd_count`  in  SIZE_CNT  number of pulses.
- `output_data`  out  SIZE_OUT  sample stream, valid every cycle.
- `pulse_mark`  out  1  high in the cycle a pulse step first appears on `output_data`.

## Operation

- FSM states:
  - `IDLE`: `cmd_ready`=1.
  - `RUN`: `cmd_ready`=0.
- A handshake is `cmd_valid && cmd_ready` at a rising edge.
  - On a handshake, latch `amp`, `period`, and `remaining <= cmd_count`, set `per_cnt <= 0`, and go to `RUN`.
  - A `cmd_period` of 0 is treated as 1.
  - A `cmd_count` of 0 is accepted and discarded; the FSM stays in `IDLE`.
  - Commands presented while in `RUN` are ignored; `cmd_valid` has no effect there.
- In `RUN`, a *fire* occurs when `per_cnt == 0`. On a fire:
  - `per_cnt <= period-1` and `remaining <= remaining-1`.
  - If `remaining == 1`, go to `IDLE`.
  - When not firing, `per_cnt` decrements.
- Tail register `tail` (SIZE_OUT bits, unsigned) updates every cycle in every state:
  - `dec = tail >> TAU_SHIFT`; if `dec == 0` and `tail != 0`, then `dec = 1`, so the tail always reaches 0.
  - `nxt = tail - dec + (fire ? amp : 0)`, computed in SIZE_OUT+1 bits and clamped to 2^SIZE_OUT-1.
- `output_data` is `tail`, registered directly. `pulse_mark` is the registered value of fire.
- Successive pulses pile up on the undecayed tail; this is intended, for filter pile-up testing.

## Timing

- Reset values: `output_data`=0, `pulse_mark`=0, `cmd_ready`=1, state `IDLE`, all counters 0.
- Reset applies at the next edge regardless of state. A run in progress is aborted with no further pulses, and the tail is cleared to 0, not decayed.
- Handshake cycle is C0:
  - C1: `RUN`, no fire yet.
  - First fire at end of C1.
  - C2: `output_data` includes the step and `pulse_mark`=1.
- Subsequent fires occur exactly `period` cycles apart.
- After the last fire, `cmd_ready` is high in the same cycle the last step appears on `output_data`. A new handshake in that cycle fires two cycles later, with no pulse lost.
- `period` = 1 fires every cycle.

## Structure

- Package `v3_param` gains:
  - `TAU_SHIFT` and the SIZE_AMP/PER/CNT constants.
  - `typedef enum logic {IDLE, RUN} pg_state_t`.
- Natural sub-module `v3_decay_acc` holds the `tail` register, decay, injection and saturation. Its inputs are `fire` and `amp`; its output is the sample.
- The top level holds the FSM, the counters and the handshake.

## Test plan

- Reset → `output_data`=0, `pulse_mark`=0, `cmd_ready`=1.
- `TAU_SHIFT`=4; command amp=1600, count=1, period=10 → `output_data` sequence C2..C5 = 1600, 1500, 1407, 1320; `pulse_mark` high only in C2; `cmd_ready` low in C1 only. The tail then decays monotonically and holds at exactly 0.
- amp=1600, count=2, period=4 → sequence C2..C6 = 1600, 1500, 1407, 1320, 2838; `pulse_mark` high in C2 and C6.
- amp=65535, count=3, period=0 (treated as 1) → C2..C4 = 65535, 126975, 131071 (saturated, no wrap).
- `reset` asserted for 1 cycle in the middle of count=10, period=5 → next cycle `output_data`=0 and `cmd_ready`=1; no `pulse_mark` thereafter.
- Commands with `cmd_valid` held high during `RUN` are ignored, and a command with count=0 is accepted with `cmd_ready` staying 1 → both produce no pulses.
